// File: rtl/wb_slice.sv
// Writeback stage: holds the MEM-stage result, waits on variable-latency data
// memory, drives the register-file write port, raises RET redirects and counts retirements.
module wb_slice #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [6:0]  WB_in,
  input  logic        MemRead_in,
  input  logic [15:0] alu_result,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        stall,
  input  logic        flush,
  output logic [3:0]  write_addr,
  output logic [15:0] write_data,
  output logic        RegWrite,
  output logic        wb_stall,
  output logic        ret_valid,
  output logic [15:0] ret_pc,
  output logic        mem_err,
  output logic [15:0] retired
);

  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(MEM_TIMEOUT - 1);
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tcnt;
  logic           r_v, r_rw, r_ret, r_m2r, r_mrd, r_done;
  logic [3:0]     r_dst;
  logic [15:0]    r_alu;
  logic           r_mem_err;
  logic [15:0]    r_retired;

  logic           w_need_mem, w_commit, w_timeout, w_wb_stall, w_advance;
  logic [15:0]    w_mdata;

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_timeout   = 1'b0;
    w_wb_stall  = 1'b0;
    w_need_mem  = r_v & r_mrd;
    case (r_state)
      S_RUN: begin
        if (w_need_mem && !mem_rvalid) begin
          w_state_nxt = S_WAIT;
          w_wb_stall  = 1'b1;
        end else begin
          w_commit = r_v;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RUN;
        end else if (r_tcnt == TCNT_LAST) begin
          w_commit    = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_wb_stall = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign w_advance = !stall && !w_wb_stall;
  assign w_mdata   = w_timeout ? TIMEOUT_DATA : mem_rdata;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_tcnt    <= '0;
      r_v       <= 1'b0;
      r_dst     <= '0;
      r_rw      <= 1'b0;
      r_ret     <= 1'b0;
      r_m2r     <= 1'b0;
      r_mrd     <= 1'b0;
      r_alu     <= '0;
      r_done    <= 1'b0;
      r_mem_err <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_RUN)
        r_tcnt <= '0;
      else if (!w_commit)
        r_tcnt <= r_tcnt + TW'(1);

      if (w_timeout)
        r_mem_err <= 1'b1;

      // A stalled instruction re-commits every cycle; count it only once.
      if (w_commit && !r_done) begin
        r_retired <= r_retired + 16'd1;
        r_done    <= 1'b1;
      end

      if (w_advance) begin
        r_done <= 1'b0;
        if (flush) begin
          r_v   <= 1'b0;
          r_dst <= '0;
          r_rw  <= 1'b0;
          r_ret <= 1'b0;
          r_m2r <= 1'b0;
          r_mrd <= 1'b0;
          r_alu <= '0;
        end else begin
          r_v   <= valid_in;
          r_dst <= WB_in[6:3];
          r_rw  <= WB_in[2];
          r_ret <= WB_in[1];
          r_m2r <= WB_in[0];
          r_mrd <= MemRead_in;
          r_alu <= alu_result;
        end
      end
    end
  end

  assign write_addr = r_dst;
  assign write_data = r_m2r ? w_mdata : r_alu;
  assign RegWrite   = w_commit & r_rw;
  assign wb_stall   = w_wb_stall;
  assign ret_valid  = w_commit & r_ret;
  assign ret_pc     = ret_valid ? w_mdata : 16'h0000;
  assign mem_err    = r_mem_err;
  assign retired    = r_retired;

endmodule

// File: tb/tb_wb_slice.sv
// Self-checking bench for wb_slice: directed scenarios plus randomized traffic,
// each cycle compared against a cycle-level behavioural model of the writeback rules.
module tb_wb_slice;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, valid_in, MemRead_in, mem_rvalid, stall, flush;
  logic [6:0]  WB_in;
  logic [15:0] alu_result, mem_rdata;
  logic [3:0]  write_addr;
  logic [15:0] write_data, ret_pc, retired;
  logic        RegWrite, wb_stall, ret_valid, mem_err;

  always #5 clk = ~clk;

  wb_slice #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .WB_in(WB_in), .MemRead_in(MemRead_in),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .stall(stall), .flush(flush), .write_addr(write_addr), .write_data(write_data),
    .RegWrite(RegWrite), .wb_stall(wb_stall), .ret_valid(ret_valid), .ret_pc(ret_pc),
    .mem_err(mem_err), .retired(retired)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: the instruction in the slot, whether it is waiting on memory and for how long.
  typedef struct packed {
    bit       v;
    bit [3:0] dst;
    bit       rw, ret, m2r, mrd;
    bit [15:0] alu;
    bit       done;
  } slot_t;

  slot_t    m_slot = '0;
  bit       m_waiting = 1'b0;
  int       m_waited = 0;
  bit       m_err = 1'b0;
  bit [15:0] m_retired = '0;

  task automatic step(input bit r, input bit v, input logic [6:0] wb, input bit mrd,
                      input logic [15:0] alu, input logic [15:0] rd, input bit rv,
                      input bit st, input bit fl);
    bit hold, commit, timed_out, exp_stall;
    logic [15:0] mdata;
    @(negedge clk);
    rst = r; valid_in = v; WB_in = wb; MemRead_in = mrd; alu_result = alu;
    mem_rdata = rd; mem_rvalid = rv; stall = st; flush = fl;
    #1;
    if (!m_waiting) begin
      hold      = m_slot.v && m_slot.mrd && !rv;
      commit    = m_slot.v && !hold;
      timed_out = 1'b0;
      exp_stall = hold;
    end else begin
      hold      = 1'b0;
      timed_out = !rv && (m_waited == TO - 1);
      commit    = rv || timed_out;
      exp_stall = !commit;
    end
    mdata = timed_out ? 16'hDEAD : rd;
    check("wb_stall",   32'(wb_stall),   32'(exp_stall));
    check("RegWrite",   32'(RegWrite),   32'(commit && m_slot.rw));
    check("write_addr", 32'(write_addr), 32'(m_slot.dst));
    check("write_data", 32'(write_data), 32'(m_slot.m2r ? mdata : m_slot.alu));
    check("ret_valid",  32'(ret_valid),  32'(commit && m_slot.ret));
    check("ret_pc",     32'(ret_pc),     32'((commit && m_slot.ret) ? mdata : 16'h0));
    check("mem_err",    32'(mem_err),    32'(m_err));
    check("retired",    32'(retired),    32'(m_retired));
    if (r) begin
      m_slot = '0; m_waiting = 1'b0; m_waited = 0; m_err = 1'b0; m_retired = '0;
    end else begin
      if (commit && !m_slot.done) begin
        m_retired++;
        m_slot.done = 1'b1;
      end
      if (timed_out) m_err = 1'b1;
      if (m_waiting) begin
        if (commit) m_waiting = 1'b0;
        else m_waited++;
      end else if (hold) begin
        m_waiting = 1'b1;
        m_waited  = 0;
      end
      if (!st && !exp_stall) begin
        if (fl) m_slot = '0;
        else m_slot = '{v: v, dst: wb[6:3], rw: wb[2], ret: wb[1], m2r: wb[0],
                        mrd: mrd, alu: alu, done: 1'b0};
      end
    end
  endtask

  task automatic idle(input bit rv = 1'b0, input logic [15:0] rd = 16'h0);
    step(1'b0, 1'b0, 7'h00, 1'b0, 16'h0, rd, rv, 1'b0, 1'b0);
  endtask

  localparam logic [6:0] ADD3 = {4'h3, 1'b1, 1'b0, 1'b0};
  localparam logic [6:0] ADD6 = {4'h6, 1'b1, 1'b0, 1'b0};
  localparam logic [6:0] LW5  = {4'h5, 1'b1, 1'b0, 1'b1};
  localparam logic [6:0] RETF = {4'hF, 1'b1, 1'b1, 1'b0};

  initial begin
    int ns;
    logic [31:0] rnd;
    bit slow_mem;
    rst = 1'b1; valid_in = 1'b0; WB_in = '0; MemRead_in = 1'b0; alu_result = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 7'h00, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_wb_stall", 32'(wb_stall), 32'd0);

    // ADD commit
    step(1'b0, 1'b1, ADD3, 1'b0, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check("add_we", 32'(RegWrite), 32'd1);
    check("add_addr", 32'(write_addr), 32'h3);
    check("add_data", 32'(write_data), 32'h1234);
    idle();
    check("add_retired", 32'(retired), 32'd1);

    // LW with memory returning in the third cycle
    step(1'b0, 1'b1, LW5, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check("lw_stall1", 32'(wb_stall), 32'd1);
    idle();
    check("lw_stall2", 32'(wb_stall), 32'd1);
    step(1'b0, 1'b1, ADD6, 1'b0, 16'h0777, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    check("lw_stall3", 32'(wb_stall), 32'd0);
    check("lw_data", 32'(write_data), 32'hBEEF);
    check("lw_addr", 32'(write_addr), 32'h5);
    idle();
    check("lw_next_addr", 32'(write_addr), 32'h6);
    check("lw_next_data", 32'(write_data), 32'h0777);
    check("lw_retired", 32'(retired), 32'd2);

    // RET
    step(1'b0, 1'b1, RETF, 1'b1, 16'h0100, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 16'h2040);
    check("ret_valid", 32'(ret_valid), 32'd1);
    check("ret_pc", 32'(ret_pc), 32'h2040);
    check("ret_sp_addr", 32'(write_addr), 32'hF);
    check("ret_sp_data", 32'(write_data), 32'h0100);
    check("ret_we", 32'(RegWrite), 32'd1);
    idle();
    check("ret_pulse_end", 32'(ret_valid), 32'd0);
    check("ret_retired", 32'(retired), 32'd4);

    // Timeout
    step(1'b0, 1'b1, LW5, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (wb_stall) ns++;
      else break;
    end
    check("to_stall_cycles", 32'(ns), 32'd15);
    check("to_we", 32'(RegWrite), 32'd1);
    check("to_data", 32'(write_data), 32'hDEAD);
    idle();
    check("to_err", 32'(mem_err), 32'd1);
    repeat (3) idle();
    check("to_err_sticky", 32'(mem_err), 32'd1);
    check("to_retired", 32'(retired), 32'd5);

    // Flush, then a 4-cycle external stall on an ADD
    step(1'b0, 1'b1, ADD3, 1'b0, 16'h5555, 16'h0, 1'b0, 1'b0, 1'b1);
    idle();
    check("flush_we", 32'(RegWrite), 32'd0);
    idle();
    check("flush_retired", 32'(retired), 32'd5);
    step(1'b0, 1'b1, ADD3, 1'b0, 16'h4444, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 7'h00, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("stall_rewrite", 32'(RegWrite), 32'd1);
    end
    idle();
    idle();
    check("stall_retired", 32'(retired), 32'd6);

    // Reset while waiting on memory
    step(1'b0, 1'b1, LW5, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    step(1'b1, 1'b0, 7'h00, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rstw_we", 32'(RegWrite), 32'd0);
    check("rstw_stall", 32'(wb_stall), 32'd0);
    check("rstw_ret", 32'(ret_valid), 32'd0);
    check("rstw_err", 32'(mem_err), 32'd0);
    check("rstw_retired", 32'(retired), 32'd0);

    // Counter wrap: 65536 back-to-back ADDs
    for (int i = 0; i < 65536; i++)
      step(1'b0, 1'b1, ADD3, 1'b0, 16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
    idle();
    check("wrap_pre", 32'(retired), 32'hFFFF);
    idle();
    check("wrap_zero", 32'(retired), 32'h0000);

    // Randomized traffic with alternating fast and slow memory
    slow_mem = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) == 0) slow_mem = ($urandom_range(0, 2) == 0);
      rnd = $urandom;
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           rnd[6:0],
           ($urandom_range(0, 2) == 0),
           rnd[31:16],
           16'($urandom),
           slow_mem ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
